// File: rtl/matx_loader.sv
// matx_loader: scans the sector buffer for "MATX_TAG" and parses 32 hex entries
// into the matrix store, one byte every two clocks (address, then evaluate).
module matx_loader #(
  parameter int ADDR_W    = 9,
  parameter int N_ENTRIES = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_dout,
  output logic              mat_we,
  output logic [4:0]        mat_addr,
  output logic [7:0]        mat_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_EVAL = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
  localparam logic [1:0] P_TAG  = 2'd0;
  localparam logic [1:0] P_SEP  = 2'd1;
  localparam logic [1:0] P_LO   = 2'd2;
  localparam logic [63:0] TAG   = "MATX_TAG";
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        phase_q, phase_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [3:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [4:0]        maddr_q, maddr_d;
  logic [7:0]        mdata_q, mdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        tag_ch;
  logic              is_dig, is_hex, is_sep, fin, bad;
  logic [3:0]        nib;
  logic [5:0]        cnt_inc;
  assign tag_ch   = TAG[{~idx_q, 3'b000} +: 8];
  assign is_dig   = ram_dout >= 8'h30 && ram_dout <= 8'h39;
  assign is_hex   = is_dig || (ram_dout >= 8'h41 && ram_dout <= 8'h46) ||
                    (ram_dout >= 8'h61 && ram_dout <= 8'h66);
  assign is_sep   = ram_dout == 8'h0D || ram_dout == 8'h0A;
  assign nib      = is_dig ? ram_dout[3:0] : ram_dout[3:0] + 4'd9;
  assign cnt_inc  = cnt_q + 6'd1;
  assign ram_en   = state_q == S_RD;
  assign ram_addr = addr_q;
  assign busy     = state_q == S_RD || state_q == S_EVAL;
  assign mat_we   = we_q;
  assign mat_addr = maddr_q;
  assign mat_data = mdata_q;
  assign done     = done_q;
  assign error    = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    done_d  = done_q;
    err_d   = err_q;
    fin     = 1'b0;
    bad     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD;
        addr_d  = '0;
        idx_d   = '0;
        phase_d = P_TAG;
        cnt_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      S_RD: state_d = S_EVAL;
      S_EVAL: begin
        case (phase_q)
          P_TAG: begin
            // a mismatching "M" may itself be the start of the real tag
            idx_d   = ram_dout == tag_ch ? idx_q + 3'd1 : {2'b00, ram_dout == 8'h4D};
            phase_d = ram_dout == tag_ch && idx_q == 3'd7 ? P_SEP : P_TAG;
          end
          P_SEP: begin
            bad     = !is_hex && !is_sep;
            hi_d    = is_hex ? nib : hi_q;
            phase_d = is_hex ? P_LO : P_SEP;
          end
          default: begin
            bad = !is_hex;
            if (is_hex) begin
              we_d    = 1'b1;
              maddr_d = cnt_q[4:0];
              mdata_d = {hi_q, nib};
              cnt_d   = cnt_inc;
              fin     = cnt_inc == 6'(N_ENTRIES);
              phase_d = P_SEP;
            end
          end
        endcase
        if (fin) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (bad || addr_q == '1) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      phase_q <= P_TAG;
      cnt_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule
